// File: rtl/elevator_pkg.sv
// Shared types and floor-mask helpers for the SCAN elevator controller.
// Masks are sized for the largest supported car (16 floors); callers truncate.
package elevator_pkg;

  localparam int unsigned MAX_FLOORS  = 16;
  localparam int unsigned MAX_FLOOR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_e;

  // Floors strictly above the given floor.
  function automatic logic [MAX_FLOORS-1:0] above_mask(input logic [MAX_FLOOR_W-1:0] floor);
    logic [MAX_FLOORS-1:0] m;
    for (int i = 0; i < int'(MAX_FLOORS); i++) begin
      m[i] = (i > int'(floor));
    end
    return m;
  endfunction

  // Floors strictly below the given floor.
  function automatic logic [MAX_FLOORS-1:0] below_mask(input logic [MAX_FLOOR_W-1:0] floor);
    logic [MAX_FLOORS-1:0] m;
    for (int i = 0; i < int'(MAX_FLOORS); i++) begin
      m[i] = (i < int'(floor));
    end
    return m;
  endfunction

  function automatic logic [MAX_FLOORS-1:0] onehot_mask(input logic [MAX_FLOOR_W-1:0] floor);
    return MAX_FLOORS'(1) << floor;
  endfunction

endpackage

// File: rtl/elevator_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, on the last count.
module elevator_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor collective (SCAN) elevator controller: latches calls, travels and
// dwells on prescaled ticks, and serves stops in the current sweep direction first.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS   = 8,
  parameter int unsigned FLOOR_W      = $clog2(NUM_FLOORS),
  parameter int unsigned TICK_DIV     = 4,
  parameter int unsigned TRAVEL_TICKS = 2,
  parameter int unsigned DOOR_TICKS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_in,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [NUM_FLOORS-1:0] floor_onehot,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  arrive
);

  localparam int unsigned TRV_W = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int unsigned DWL_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [TRV_W-1:0] TRV_LAST = TRV_W'(TRAVEL_TICKS - 1);
  localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(DOOR_TICKS - 1);

  state_e                r_state;
  logic [FLOOR_W-1:0]    r_floor;
  logic [NUM_FLOORS-1:0] r_onehot;
  logic [NUM_FLOORS-1:0] r_pending;
  logic                  r_dir_up;
  logic                  r_moving;
  logic                  r_door_open;
  logic                  r_arrive;
  logic [TRV_W-1:0]      r_travel;
  logic [DWL_W-1:0]      r_dwell;

  state_e                w_state_nxt;
  logic [FLOOR_W-1:0]    w_floor_nxt;
  logic [NUM_FLOORS-1:0] w_pending_nxt;
  logic [NUM_FLOORS-1:0] w_served;
  logic                  w_dir_nxt;
  logic                  w_arrive_nxt;
  logic [TRV_W-1:0]      w_travel_nxt;
  logic [DWL_W-1:0]      w_dwell_nxt;
  logic                  w_tick;
  logic                  w_up_req;
  logic                  w_dn_req;
  logic                  w_ahead;
  logic [FLOOR_W-1:0]    w_step_floor;
  logic                  w_step_ahead;

  elevator_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // Direction requests look only at registered pending calls.
  assign w_up_req = |(r_pending & NUM_FLOORS'(above_mask(MAX_FLOOR_W'(r_floor))));
  assign w_dn_req = |(r_pending & NUM_FLOORS'(below_mask(MAX_FLOOR_W'(r_floor))));
  assign w_ahead  = r_dir_up ? w_up_req : w_dn_req;

  // Floor the car would reach on the next step, and whether work remains beyond it.
  assign w_step_floor = r_dir_up ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));
  assign w_step_ahead = r_dir_up ?
      |(r_pending & NUM_FLOORS'(above_mask(MAX_FLOOR_W'(w_step_floor)))) :
      |(r_pending & NUM_FLOORS'(below_mask(MAX_FLOOR_W'(w_step_floor))));

  always_comb begin
    w_state_nxt   = r_state;
    w_floor_nxt   = r_floor;
    w_dir_nxt     = r_dir_up;
    w_arrive_nxt  = 1'b0;
    w_travel_nxt  = r_travel;
    w_dwell_nxt   = r_dwell;
    w_served      = '0;
    w_pending_nxt = r_pending;

    case (r_state)
      IDLE: begin
        if (r_pending[r_floor]) begin
          w_state_nxt = DOOR;
          w_dwell_nxt = '0;
        end else if (w_up_req && (r_dir_up || !w_dn_req)) begin
          w_state_nxt  = MOVE;
          w_dir_nxt    = 1'b1;
          w_travel_nxt = '0;
        end else if (w_dn_req) begin
          w_state_nxt  = MOVE;
          w_dir_nxt    = 1'b0;
          w_travel_nxt = '0;
        end
      end

      MOVE: begin
        // Without work ahead the car never steps, which also keeps it inside the shaft.
        if (!w_ahead) begin
          w_state_nxt  = IDLE;
          w_travel_nxt = '0;
        end else if (w_tick) begin
          if (r_travel == TRV_LAST) begin
            w_travel_nxt = '0;
            w_floor_nxt  = w_step_floor;
            w_arrive_nxt = 1'b1;
            if (r_pending[w_step_floor]) begin
              w_state_nxt = DOOR;
              w_dwell_nxt = '0;
            end else if (!w_step_ahead) begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_travel_nxt = r_travel + TRV_W'(1);
          end
        end
      end

      DOOR: begin
        if (call_in[r_floor] || door_hold) begin
          w_dwell_nxt = '0;
        end else if (w_tick) begin
          if (r_dwell == DWL_LAST) begin
            w_state_nxt = IDLE;
            w_dwell_nxt = '0;
          end else begin
            w_dwell_nxt = r_dwell + DWL_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // The floor being served wins over a same-cycle call to it.
    if ((r_state == DOOR) || (w_state_nxt == DOOR)) begin
      w_served = NUM_FLOORS'(onehot_mask(MAX_FLOOR_W'(w_floor_nxt)));
    end
    w_pending_nxt = (r_pending | call_in) & ~w_served;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_floor     <= '0;
      r_onehot    <= NUM_FLOORS'(1);
      r_pending   <= '0;
      r_dir_up    <= 1'b1;
      r_moving    <= 1'b0;
      r_door_open <= 1'b0;
      r_arrive    <= 1'b0;
      r_travel    <= '0;
      r_dwell     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_floor     <= w_floor_nxt;
      r_onehot    <= NUM_FLOORS'(onehot_mask(MAX_FLOOR_W'(w_floor_nxt)));
      r_pending   <= w_pending_nxt;
      r_dir_up    <= w_dir_nxt;
      r_moving    <= (w_state_nxt == MOVE);
      r_door_open <= (w_state_nxt == DOOR);
      r_arrive    <= w_arrive_nxt;
      r_travel    <= w_travel_nxt;
      r_dwell     <= w_dwell_nxt;
    end
  end

  assign cur_floor    = r_floor;
  assign floor_onehot = r_onehot;
  assign pending      = r_pending;
  assign moving       = r_moving;
  assign dir_up       = r_dir_up;
  assign door_open    = r_door_open;
  assign arrive       = r_arrive;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Self-checking bench for elevator_scan_ctrl: directed scenarios plus a randomized
// run checked cycle-by-cycle against a behavioural model of the elevator.
module tb_elevator_scan_ctrl;

  localparam int NF = 8;
  localparam int TD = 4;
  localparam int TT = 2;
  localparam int DT = 3;

  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] call_in = '0;
  logic          door_hold = 1'b0;
  logic [2:0]    cur_floor;
  logic [NF-1:0] floor_onehot;
  logic [NF-1:0] pending;
  logic          moving;
  logic          dir_up;
  logic          door_open;
  logic          arrive;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model of the car (values as seen after the latest clock edge).
  int            m_floor, m_mode, m_trav, m_dwell, m_pre;
  bit            m_dir, m_arrive;
  logic [NF-1:0] m_pend;

  elevator_scan_ctrl #(
    .NUM_FLOORS   (NF),
    .TICK_DIV     (TD),
    .TRAVEL_TICKS (TT),
    .DOOR_TICKS   (DT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .call_in      (call_in),
    .door_hold    (door_hold),
    .cur_floor    (cur_floor),
    .floor_onehot (floor_onehot),
    .pending      (pending),
    .moving       (moving),
    .dir_up       (dir_up),
    .door_open    (door_open),
    .arrive       (arrive)
  );

  always #5 clk = ~clk;

  function automatic bit any_above(input int f);
    for (int i = f + 1; i < NF; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input int f);
    for (int i = 0; i < f; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Clock edges until the door closes, given the prescaler phase with dwell just cleared.
  function automatic int close_edges(input int p);
    return ((TD - 1 - p) % TD) + 1 + (DT - 1) * TD;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_mode = M_IDLE; m_trav = 0; m_dwell = 0; m_pre = 0;
    m_dir = 1'b1; m_arrive = 1'b0; m_pend = '0;
  endtask

  task automatic model_step(input logic [NF-1:0] c, input bit h);
    bit tick;
    int nf, nmode, ntrav, ndwell;
    bit ndir, narr, ahead;
    tick = (m_pre == TD - 1);
    nf = m_floor; nmode = m_mode; ntrav = m_trav; ndwell = m_dwell;
    ndir = m_dir; narr = 1'b0;
    if (m_mode == M_IDLE) begin
      if (m_pend[m_floor]) begin
        nmode = M_DOOR; ndwell = 0;
      end else if (any_above(m_floor) && (m_dir || !any_below(m_floor))) begin
        nmode = M_MOVE; ndir = 1'b1; ntrav = 0;
      end else if (any_below(m_floor)) begin
        nmode = M_MOVE; ndir = 1'b0; ntrav = 0;
      end
    end else if (m_mode == M_MOVE) begin
      ahead = m_dir ? any_above(m_floor) : any_below(m_floor);
      if (!ahead) begin
        nmode = M_IDLE; ntrav = 0;
      end else if (tick) begin
        ntrav = m_trav + 1;
        if (ntrav == TT) begin
          ntrav = 0;
          nf = m_dir ? m_floor + 1 : m_floor - 1;
          narr = 1'b1;
          if (m_pend[nf]) begin
            nmode = M_DOOR; ndwell = 0;
          end else if (!(m_dir ? any_above(nf) : any_below(nf))) begin
            nmode = M_IDLE;
          end
        end
      end
    end else begin
      if (c[m_floor] || h) begin
        ndwell = 0;
      end else if (tick) begin
        ndwell = m_dwell + 1;
        if (ndwell == DT) begin
          nmode = M_IDLE; ndwell = 0;
        end
      end
    end
    m_pend = m_pend | c;
    if (m_mode == M_DOOR || nmode == M_DOOR) m_pend[nf] = 1'b0;
    m_floor = nf; m_mode = nmode; m_trav = ntrav; m_dwell = ndwell;
    m_dir = ndir; m_arrive = narr;
    m_pre = (m_pre + 1) % TD;
  endtask

  // One clock: drive inputs at the falling edge, advance the model, sample after the rising edge.
  task automatic cyc(input logic [NF-1:0] c, input bit h);
    @(negedge clk);
    call_in = c;
    door_hold = h;
    if (!reset) model_step(c, h);
    @(posedge clk);
    #1;
    call_in = '0;
    door_hold = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_door(input bit want, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (door_open === want) begin
        ok = 1'b1;
        break;
      end
      cyc('0, 1'b0);
    end
  endtask

  task automatic count_open(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      cyc('0, 1'b0);
      if (door_open !== 1'b1) break;
      n++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if ({cur_floor, floor_onehot, pending} !== {3'd0, 8'h01, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_vectors: got floor=%0d onehot=%h pend=%h want 0/01/00", cur_floor, floor_onehot, pending);
    end
    n_cmp++;
    if ({moving, dir_up, door_open, arrive} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_flags: got mv/up/door/arr=%b want 0100", {moving, dir_up, door_open, arrive});
    end
    do_reset();
    repeat (10) cyc('0, 1'b0);
    n_cmp++;
    if ({cur_floor, moving, door_open, pending} !== {3'd0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_quiet: got floor=%0d mv=%b door=%b pend=%h want parked at 0", cur_floor, moving, door_open, pending);
    end
  endtask

  task automatic test_single_call();
    int arrives, last_arr, bad_gaps, opened, p, exp_open;
    bit ok;
    do_reset();
    cyc(8'h20, 1'b0);
    n_cmp++;
    if (pending !== 8'h20) begin
      n_fail++;
      $display("FAIL single_latch: pending=%h want 20", pending);
    end
    cyc('0, 1'b0);
    n_cmp++;
    if (moving !== 1'b1) begin
      n_fail++;
      $display("FAIL single_depart: moving=%b want 1", moving);
    end
    arrives = 0; last_arr = -1; bad_gaps = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (arrive === 1'b1) begin
        if (last_arr >= 0 && (i - last_arr) != TT * TD) bad_gaps++;
        last_arr = i;
        arrives++;
      end
      if (door_open === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc('0, 1'b0);
    end
    n_cmp++;
    if (!ok || arrives != 5 || bad_gaps != 0) begin
      n_fail++;
      $display("FAIL single_travel: door_seen=%b arrives=%0d bad_gaps=%0d want 1/5/0", ok, arrives, bad_gaps);
    end
    n_cmp++;
    if ({cur_floor, floor_onehot, pending} !== {3'd5, 8'h20, 8'h00}) begin
      n_fail++;
      $display("FAIL single_stop: floor=%0d onehot=%h pend=%h want 5/20/00", cur_floor, floor_onehot, pending);
    end
    p = m_pre;
    exp_open = close_edges(p) - 1;
    count_open(opened);
    n_cmp++;
    if (opened != exp_open || moving !== 1'b0 || door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL single_dwell: open_cycles=%0d mv=%b door=%b want %0d/0/0", opened, moving, door_open, exp_open);
    end
  endtask

  task automatic test_sweep_pickup();
    bit ok, seen;
    do_reset();
    cyc(8'h20, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc('0, 1'b0);
      if (cur_floor === 3'd1 && moving === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    cyc(8'h04, 1'b0);
    wait_door(1'b1, 200, ok);
    n_cmp++;
    if (!seen || !ok || cur_floor !== 3'd2 || dir_up !== 1'b1 || pending !== 8'h20) begin
      n_fail++;
      $display("FAIL sweep_first_stop: seen=%b ok=%b floor=%0d up=%b pend=%h want 1/1/2/1/20", seen, ok, cur_floor, dir_up, pending);
    end
    wait_door(1'b0, 200, ok);
    wait_door(1'b1, 200, ok);
    n_cmp++;
    if (!ok || cur_floor !== 3'd5 || dir_up !== 1'b1 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL sweep_second_stop: ok=%b floor=%0d up=%b pend=%h want 1/5/1/00", ok, cur_floor, dir_up, pending);
    end
    wait_door(1'b0, 200, ok);
  endtask

  task automatic test_reverse();
    bit ok;
    do_reset();
    cyc(8'h10, 1'b0);
    wait_door(1'b1, 200, ok);
    wait_door(1'b0, 200, ok);
    cyc(8'h42, 1'b0);
    wait_door(1'b1, 200, ok);
    n_cmp++;
    if (!ok || cur_floor !== 3'd6 || dir_up !== 1'b1 || pending !== 8'h02) begin
      n_fail++;
      $display("FAIL reverse_up_first: ok=%b floor=%0d up=%b pend=%h want 1/6/1/02", ok, cur_floor, dir_up, pending);
    end
    wait_door(1'b0, 200, ok);
    wait_door(1'b1, 200, ok);
    n_cmp++;
    if (!ok || cur_floor !== 3'd1 || dir_up !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL reverse_down: ok=%b floor=%0d up=%b pend=%h want 1/1/0/00", ok, cur_floor, dir_up, pending);
    end
    wait_door(1'b0, 200, ok);
  endtask

  task automatic test_door_extend();
    bit ok, hit;
    int opened, exp_open;
    do_reset();
    cyc(8'h08, 1'b0);
    wait_door(1'b1, 200, ok);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_dwell == 2) begin
        hit = 1'b1;
        break;
      end
      cyc('0, 1'b0);
    end
    cyc(8'h08, 1'b0);
    n_cmp++;
    if (!ok || !hit || door_open !== 1'b1 || pending[3] !== 1'b0 || cur_floor !== 3'd3) begin
      n_fail++;
      $display("FAIL extend_pulse: ok=%b hit=%b door=%b pend=%h floor=%0d want 1/1/1/00/3", ok, hit, door_open, pending, cur_floor);
    end
    exp_open = close_edges(m_pre) - 1;
    count_open(opened);
    n_cmp++;
    if (opened != exp_open) begin
      n_fail++;
      $display("FAIL extend_dwell: open_cycles=%0d want %0d", opened, exp_open);
    end
  endtask

  task automatic test_idle_call();
    cyc('0, 1'b0);
    cyc(8'h08, 1'b0);
    n_cmp++;
    if (door_open !== 1'b0 || pending !== 8'h08 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_call_latch: door=%b pend=%h mv=%b want 0/08/0", door_open, pending, moving);
    end
    cyc('0, 1'b0);
    n_cmp++;
    if ({door_open, arrive, moving, cur_floor, pending} !== {1'b1, 1'b0, 1'b0, 3'd3, 8'h00}) begin
      n_fail++;
      $display("FAIL idle_call_open: door=%b arr=%b mv=%b floor=%0d pend=%h want 1/0/0/3/00", door_open, arrive, moving, cur_floor, pending);
    end
  endtask

  task automatic test_door_hold();
    int closed, opened, exp_open;
    closed = 0;
    for (int i = 0; i < 10 * TD; i++) begin
      cyc((i == 5) ? 8'h08 : 8'h00, 1'b1);
      if (door_open !== 1'b1 || pending[3] !== 1'b0) closed++;
    end
    n_cmp++;
    if (closed != 0) begin
      n_fail++;
      $display("FAIL hold_keeps_open: bad_cycles=%0d want 0", closed);
    end
    exp_open = close_edges(m_pre) - 1;
    count_open(opened);
    n_cmp++;
    if (opened != exp_open) begin
      n_fail++;
      $display("FAIL hold_release: open_cycles=%0d want %0d", opened, exp_open);
    end
  endtask

  task automatic test_reset_mid_move();
    bit seen;
    do_reset();
    cyc(8'h80, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc('0, 1'b0);
      if (cur_floor === 3'd2 && arrive === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (3) cyc('0, 1'b0);
    n_cmp++;
    if (!seen || moving !== 1'b1 || pending !== 8'h80 || cur_floor !== 3'd2) begin
      n_fail++;
      $display("FAIL midmove_setup: seen=%b mv=%b pend=%h floor=%0d want 1/1/80/2", seen, moving, pending, cur_floor);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({cur_floor, floor_onehot, pending, moving, dir_up, door_open, arrive} !==
        {3'd0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midmove_async_reset: floor=%0d oh=%h pend=%h mv/up/door/arr=%b want 0/01/00/0100",
               cur_floor, floor_onehot, pending, {moving, dir_up, door_open, arrive});
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [NF-1:0] c;
    logic [NF-1:0] exp_oh;
    bit h;
    int hold_left;
    do_reset();
    hold_left = 0;
    for (int n = 0; n < 3000; n++) begin
      c = '0;
      if ($urandom_range(0, 11) == 0) c = NF'(1) << $urandom_range(0, NF - 1);
      if ($urandom_range(0, 59) == 0) c = NF'($urandom);
      if (hold_left == 0 && $urandom_range(0, 79) == 0) hold_left = $urandom_range(1, 3 * TD);
      h = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      cyc(c, h);
      exp_oh = NF'(1) << m_floor;
      n_cmp++;
      if ({cur_floor, floor_onehot, pending, moving, dir_up, door_open, arrive} !==
          {3'(m_floor), exp_oh, m_pend, (m_mode == M_MOVE), m_dir, (m_mode == M_DOOR), m_arrive}) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got floor=%0d oh=%h pend=%h mv=%b up=%b door=%b arr=%b want floor=%0d oh=%h pend=%h mv=%b up=%b door=%b arr=%b",
                 n, cur_floor, floor_onehot, pending, moving, dir_up, door_open, arrive,
                 m_floor, exp_oh, m_pend, (m_mode == M_MOVE), m_dir, (m_mode == M_DOOR), m_arrive);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_call();
    test_sweep_pickup();
    test_reverse();
    test_door_extend();
    test_idle_call();
    test_door_hold();
    test_reset_mid_move();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
